// File: rtl/afifo_rd_packer.sv
// Read-domain packer: pops DSIZE-bit words from an async FIFO and packs RATIO of them
// into one wide beat on a single-stage registered valid/ready stream, with flush support.
module afifo_rd_packer #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                            rclk,
  input  logic                            rrst_n,
  input  logic                            rempty,
  input  logic [DSIZE-1:0]                rdata,
  output logic                            rinc,
  input  logic                            flush,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DSIZE*RATIO-1:0]          m_data,
  output logic [$clog2(RATIO):0]          m_cnt,
  output logic [$clog2(RATIO)-1:0]        pend_cnt
);

  localparam int unsigned OSIZE = DSIZE * RATIO;
  localparam int unsigned CW    = $clog2(RATIO) + 1;
  localparam int unsigned IW    = $clog2(RATIO);

  typedef enum logic {FILL, FLUSH_WAIT} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [OSIZE-1:0] lanes, lanes_n, filled;
  logic [OSIZE-1:0] m_data_n;
  logic [CW-1:0]    m_cnt_n, fill_cnt;
  logic             m_valid_n;
  logic             out_free, last_lane;

  assign out_free  = !m_valid || m_ready;
  assign last_lane = (idx == IW'(RATIO - 1));
  // A word that would complete a beat is only popped when the output slot can take it.
  assign rinc      = rrst_n && !rempty && (state == FILL) && (!last_lane || out_free);
  assign pend_cnt  = idx;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    lanes_n   = lanes;
    m_valid_n = m_valid && !m_ready;
    m_data_n  = m_data;
    m_cnt_n   = m_cnt;
    filled    = lanes;
    fill_cnt  = CW'(idx) + CW'(rinc);
    if (rinc) filled[idx*DSIZE +: DSIZE] = rdata;

    case (state)
      FILL: begin
        if (rinc && last_lane) begin
          m_data_n  = {rdata, lanes[OSIZE-DSIZE-1:0]};
          m_cnt_n   = CW'(RATIO);
          m_valid_n = 1'b1;
          idx_n     = '0;
          lanes_n   = '0;
        end else begin
          if (rinc) begin
            lanes_n = filled;
            idx_n   = idx + IW'(1);
          end
          // Flush emits whatever is held (including a same-edge pop); empty beats never go out.
          if (flush && (fill_cnt != '0)) begin
            if (out_free) begin
              m_data_n  = filled;
              m_cnt_n   = fill_cnt;
              m_valid_n = 1'b1;
              idx_n     = '0;
              lanes_n   = '0;
            end else begin
              state_n = FLUSH_WAIT;
            end
          end
        end
      end
      FLUSH_WAIT: begin
        if (out_free) begin
          m_data_n  = lanes;
          m_cnt_n   = CW'(idx);
          m_valid_n = 1'b1;
          idx_n     = '0;
          lanes_n   = '0;
          state_n   = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state   <= FILL;
      idx     <= '0;
      lanes   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_cnt   <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      lanes   <= lanes_n;
      m_valid <= m_valid_n;
      m_data  <= m_data_n;
      m_cnt   <= m_cnt_n;
    end
  end

endmodule
